cacheline_fill_unit: RTL and testbench
======================================

# cacheline_fill_unit

Miss-handling stage directly downstream of the data cache (`cache_2`). On a cache miss the cache hands this block the missing address and, when the victim is dirty, the victim line. The block writes the victim back word by word, fetches the new line from the memory bus, and returns the assembled line to the cache in a single fill pulse. It handles one miss at a time, with a blocking request handshake.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, memory bus word width in bits
- `ENTRY_SIZE_BYTES`, 4, bytes per word; must equal `DATA_WIDTH/8`
- `ENTRIES_PER_CACHELINE`, 4, words per line; power of two, ≥2
- `clk`  in  1  clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `miss_valid`  in  1  miss request present
- `miss_ready`  out  1  block idle; request accepted on `miss_valid & miss_ready`
- `miss_addr`  in  `ADDRESS_WIDTH`  byte address of the missing access
- `evict_dirty`  in  1  victim line must be written back
- `evict_addr`  in  `ADDRESS_WIDTH`  victim line address; low offset bits ignored
- `evict_data`  in  `DATA_WIDTH*ENTRIES_PER_CACHELINE`  victim line; word 0 in the LSBs
- `mem_req`  out  1  bus beat request
- `mem_we`  out  1  1 = write beat, 0 = read beat
- `mem_addr`  out  `ADDRESS_WIDTH`  word-aligned beat address
- `mem_wdata`  out  `DATA_WIDTH`  write data
- `mem_ack`  in  1  beat completes on an edge where `mem_req & mem_ack`
- `mem_rdata`  in  `DATA_WIDTH`  read data, valid with `mem_ack`
- `fill_valid`  out  1  one-cycle pulse: fill line is ready
- `fill_addr`  out  `ADDRESS_WIDTH`  line-aligned fill address
- `fill_data`  out  `DATA_WIDTH*ENTRIES_PER_CACHELINE`  fetched line; word 0 in the LSBs
- `crit_valid`  out  1  one-cycle pulse when the critical word has arrived (see Configuration)
- `crit_data`  out  `DATA_WIDTH`  critical word

## Operation
- Offset width: `OFF = log2(ENTRIES_PER_CACHELINE*ENTRY_SIZE_BYTES)`.
- Line base address: the input address with its low `OFF` bits cleared.
- Beat address: line base + `beat*ENTRY_SIZE_BYTES`.
- The beat counter is `log2(ENTRIES_PER_CACHELINE)` bits wide and wraps modulo `ENTRIES_PER_CACHELINE`.
- On accept, the block registers `miss_addr`, `evict_dirty`, `evict_addr` and `evict_data`. Inputs are don't-care afterwards.
- FSM states:
  - `IDLE`: `miss_ready`=1. On accept, go to `WRITEBACK` if `evict_dirty`, else to `FILL`.
  - `WRITEBACK`: `mem_req`=1, `mem_we`=1, data = victim word[beat], beats 0..N-1 in order. After the last ack, go to `FILL`.
  - `FILL`: `mem_req`=1, `mem_we`=0. On each ack, `mem_rdata` is written into line buffer word[beat]. After the last ack, go to `RESPOND`.
  - `RESPOND`: `fill_valid`=1 for exactly one cycle, then go to `IDLE`.
- Handshake rules:
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` is high and no ack has occurred.
  - After an ack, the next beat's address is presented the following cycle; `mem_req` stays high between beats.
  - `mem_ack` is ignored while `mem_req` is 0.
- `fill_valid` has no backpressure; the cache must consume the fill in the pulse cycle.
- `fill_addr` and `fill_data` hold their values until the next fill.
- Reset values: `miss_ready`=1 after reset. `mem_req`, `mem_we`, `fill_valid` and `crit_valid`=0. `mem_addr`, `mem_wdata`, `fill_addr`, `fill_data` and `crit_data`=0.
- Reset mid-operation: the in-flight miss is dropped, the FSM goes to `IDLE`, and `mem_req` is 0 in the cycle after reset is sampled. No `fill_valid` is produced for the dropped miss.

## Timing
- Accept at edge E0. `mem_req` is high from cycle E0+1; all outputs are registered.
- With zero wait-state memory (ack in every request cycle), each beat costs 1 cycle.
- Clean miss: `fill_valid` is high in cycle E0+1+N, where N = `ENTRIES_PER_CACHELINE` (E0+5 for N=4).
- Dirty miss: add N cycles.
- Each wait state (cycle with `mem_req` high and `mem_ack` low) adds 1 cycle.
- `miss_ready` returns to 1 in the cycle after `fill_valid`. Minimum back-to-back miss spacing for N=4 clean misses is 6 cycles.

## Configuration
- `CACHELINE_FILL_CWF_EN` defined (critical word first):
  - `FILL` starts at beat = `miss_addr[OFF-1:log2(ENTRY_SIZE_BYTES)]` and wraps modulo N.
  - `crit_valid` pulses, and `crit_data` is registered, the cycle after the first fill ack.
  - Fill latency is unchanged.
  - `WRITEBACK` order is unaffected.
- Not defined:
  - `FILL` starts at beat 0.
  - `crit_valid` and `crit_data` are tied to 0.

## Structure
- Shared package `cache_pkg` holds:
  - the FSM state enum `fill_state_t` (`IDLE`, `WRITEBACK`, `FILL`, `RESPOND`);
  - the packed struct `miss_req_t` (`addr`, `evict_dirty`, `evict_addr`, `evict_data`);
  - the offset-width helper constant.
- Single module, no sub-module: the FSM, beat counter and line buffer are tightly coupled.

## Test plan
- Clean miss, `miss_addr`=0x0000_1234, memory returns `addr^0xA5A5A5A5`, zero wait states -> read beats at 0x1230, 0x1234, 0x1238, 0x123C; `fill_valid` at E0+5; `fill_addr`=0x1230; each word matches.
- Dirty miss, `evict_addr`=0x0000_2000 with data {4,3,2,1} -> write beats at 0x2000..0x200C carrying 1,2,3,4, then 4 reads; `fill_valid` at E0+9.
- Ack held low for 3 cycles on beat 2 -> `mem_addr` stays stable, `fill_valid` is delayed by exactly 3 cycles, no beat is duplicated or skipped.
- Reset asserted during `FILL` beat 1 -> `mem_req` is 0 the next cycle; no `fill_valid`; `miss_ready`=1; a new miss then completes normally.
- `miss_valid` held high during a busy miss -> second request accepted only once `miss_ready`=1; exactly one fill per accept.
- With `CACHELINE_FILL_CWF_EN`, `miss_addr`=0x0000_123C -> read order 0x123C, 0x1230, 0x1234, 0x1238; `crit_valid` the cycle after the first ack with `crit_data` = first `mem_rdata`; `fill_data` is correctly placed.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache miss path: fill FSM states, the
// registered miss request and the line-offset width helper.
package cache_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = DATA_W * LINE_WORDS;

  function automatic int offset_width(input int words, input int bytes_per_word);
    return $clog2(words * bytes_per_word);
  endfunction

  localparam int OFF_W = offset_width(LINE_WORDS, WORD_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL,
    RESPOND
  } fill_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              evict_dirty;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
  } miss_req_t;

endpackage

// File: rtl/cacheline_fill_unit_if.sv
// Single-beat memory bus between the fill unit (master) and the memory side (slave).
interface cacheline_fill_unit_if
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int DATA_WIDTH    = DATA_W
);

  logic                     mem_req;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_ack;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cacheline_fill_unit.sv
// Cache miss handler: optional victim writeback, line fetch over a single-beat bus,
// one-cycle fill pulse. Define CACHELINE_FILL_CWF_EN for critical-word-first fetch.
module cacheline_fill_unit
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH         = ADDR_W,
  parameter int DATA_WIDTH            = DATA_W,
  parameter int ENTRY_SIZE_BYTES      = WORD_BYTES,
  parameter int ENTRIES_PER_CACHELINE = LINE_WORDS
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        miss_valid,
  output logic                                        miss_ready,
  input  logic [ADDRESS_WIDTH-1:0]                    miss_addr,
  input  logic                                        evict_dirty,
  input  logic [ADDRESS_WIDTH-1:0]                    evict_addr,
  input  logic [DATA_WIDTH*ENTRIES_PER_CACHELINE-1:0] evict_data,
  cacheline_fill_unit_if.master                       mem,
  output logic                                        fill_valid,
  output logic [ADDRESS_WIDTH-1:0]                    fill_addr,
  output logic [DATA_WIDTH*ENTRIES_PER_CACHELINE-1:0] fill_data,
  output logic                                        crit_valid,
  output logic [DATA_WIDTH-1:0]                       crit_data
);

  localparam int OFF       = offset_width(ENTRIES_PER_CACHELINE, ENTRY_SIZE_BYTES);
  localparam int WORD_OFF  = $clog2(ENTRY_SIZE_BYTES);
  localparam int BEAT_W    = $clog2(ENTRIES_PER_CACHELINE);
  localparam int LINE_BITS = DATA_WIDTH * ENTRIES_PER_CACHELINE;
  localparam logic [ADDRESS_WIDTH-1:0] OFF_MASK = ADDRESS_WIDTH'((64'd1 << OFF) - 64'd1);

  fill_state_t           state;
  miss_req_t             req;
  logic [BEAT_W-1:0]     beat;
  logic [BEAT_W-1:0]     next_beat;
  logic [BEAT_W-1:0]     start_new;
  logic [BEAT_W-1:0]     start_cur;
  logic [LINE_BITS-1:0]  line_buf;
  logic [LINE_BITS-1:0]  line_next;

  function automatic logic [ADDRESS_WIDTH-1:0] line_base(input logic [ADDRESS_WIDTH-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(input logic [ADDRESS_WIDTH-1:0] a,
                                                         input logic [BEAT_W-1:0]        b);
    return line_base(a) + (ADDRESS_WIDTH'(b) << WORD_OFF);
  endfunction

  // Fill starts at the requested word when critical-word-first is built in.
`ifdef CACHELINE_FILL_CWF_EN
  assign start_new = miss_addr[OFF-1:WORD_OFF];
  assign start_cur = req.addr[OFF-1:WORD_OFF];
`else
  assign start_new = '0;
  assign start_cur = '0;
`endif

  assign next_beat = beat + BEAT_W'(1);

  // NOTE: default to the held line first so every path assigns line_next and no latch is inferred.
  always_comb begin
    line_next = line_buf;
    line_next[beat*DATA_WIDTH +: DATA_WIDTH] = mem.mem_rdata;
  end

  // NOTE: request and line buffer are datapath storage with no reset; every bit is written before use.
  always_ff @(posedge clk) begin
    if (miss_valid && miss_ready) begin
      req <= '{addr: miss_addr, evict_dirty: evict_dirty,
               evict_addr: evict_addr, evict_data: evict_data};
    end
    if (state == FILL && mem.mem_ack) begin
      line_buf <= line_next;
    end
  end

  // NOTE: all state here updates with non-blocking assignments so reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      beat          <= '0;
      miss_ready    <= 1'b1;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      fill_valid    <= 1'b0;
      fill_addr     <= '0;
      fill_data     <= '0;
    end else begin
      fill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_valid && miss_ready) begin
            miss_ready  <= 1'b0;
            mem.mem_req <= 1'b1;
            if (evict_dirty) begin
              state         <= WRITEBACK;
              beat          <= '0;
              mem.mem_we    <= 1'b1;
              mem.mem_addr  <= line_base(evict_addr);
              mem.mem_wdata <= evict_data[DATA_WIDTH-1:0];
            end else begin
              state        <= FILL;
              beat         <= start_new;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= beat_addr(miss_addr, start_new);
            end
          end
        end
        WRITEBACK: begin
          if (mem.mem_ack) begin
            if (next_beat == '0) begin
              state        <= FILL;
              beat         <= start_cur;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= beat_addr(req.addr, start_cur);
            end else begin
              beat          <= next_beat;
              mem.mem_we    <= req.evict_dirty;
              mem.mem_addr  <= beat_addr(req.evict_addr, next_beat);
              mem.mem_wdata <= req.evict_data[next_beat*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        FILL: begin
          if (mem.mem_ack) begin
            if (next_beat == start_cur) begin
              state       <= RESPOND;
              mem.mem_req <= 1'b0;
              fill_valid  <= 1'b1;
              fill_addr   <= line_base(req.addr);
              fill_data   <= line_next;
            end else begin
              beat         <= next_beat;
              mem.mem_addr <= beat_addr(req.addr, next_beat);
            end
          end
        end
        RESPOND: begin
          state      <= IDLE;
          miss_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHELINE_FILL_CWF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= 1'b0;
      // The fill visits each beat once, so beat == start marks the first ack.
      if (state == FILL && mem.mem_ack && beat == start_cur) begin
        crit_valid <= 1'b1;
        crit_data  <= mem.mem_rdata;
      end
    end
  end
`else
  assign crit_valid = 1'b0;
  assign crit_data  = '0;
`endif

endmodule

// File: tb/tb_cacheline_fill_unit.sv
// Directed bench for cacheline_fill_unit: clean, dirty, wait-state, reset-abort and
// back-to-back misses against a memory model returning addr ^ 0xA5A5A5A5.
module tb_cacheline_fill_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_valid;
  logic         miss_ready;
  logic [31:0]  miss_addr;
  logic         evict_dirty;
  logic [31:0]  evict_addr;
  logic [127:0] evict_data;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         crit_valid;
  logic [31:0]  crit_data;

  cacheline_fill_unit_if bus ();

  cacheline_fill_unit dut (
    .clk        (clk),
    .reset      (reset),
    .miss_valid (miss_valid),
    .miss_ready (miss_ready),
    .miss_addr  (miss_addr),
    .evict_dirty(evict_dirty),
    .evict_addr (evict_addr),
    .evict_data (evict_data),
    .mem        (bus),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .crit_valid (crit_valid),
    .crit_data  (crit_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0]  beat_addr_q[$];
  logic         beat_we_q[$];
  logic [31:0]  beat_wdata_q[$];
  int           fill_cyc_q[$];
  logic [31:0]  fill_addr_q[$];
  logic [127:0] fill_data_q[$];
  int           crit_cyc_q[$];
  logic [31:0]  crit_data_q[$];
  int           crit_total = 0;
  logic [31:0]  stall_addr = 32'hFFFF_FFFF;
  int           stall_left = 0;
  int           stall_seen = 0;

  // Memory model: acks every request cycle unless stalling on stall_addr; acks when idle too.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (bus.mem_addr == stall_addr && stall_left > 0) begin
        bus.mem_ack = 1'b0;
        stall_left--;
        stall_seen++;
      end else begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ 32'hA5A5_A5A5;
        beat_addr_q.push_back(bus.mem_addr);
        beat_we_q.push_back(bus.mem_we);
        beat_wdata_q.push_back(bus.mem_wdata);
      end
    end else begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    if (fill_valid) begin
      fill_cyc_q.push_back(cyc);
      fill_addr_q.push_back(fill_addr);
      fill_data_q.push_back(fill_data);
    end
    if (crit_valid) begin
      crit_cyc_q.push_back(cyc);
      crit_data_q.push_back(crit_data);
      crit_total++;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    beat_addr_q.delete();
    beat_we_q.delete();
    beat_wdata_q.delete();
    fill_cyc_q.delete();
    fill_addr_q.delete();
    fill_data_q.delete();
    crit_cyc_q.delete();
    crit_data_q.delete();
  endtask

  // Presents a miss and returns the accept edge index (cycle count after that posedge).
  task automatic start_miss(input logic [31:0] a, input logic d, input logic [31:0] ea,
                            input logic [127:0] ed, input bit hold, output int e0);
    @(negedge clk);
    miss_valid  = 1'b1;
    miss_addr   = a;
    evict_dirty = d;
    evict_addr  = ea;
    evict_data  = ed;
    e0 = -1;
    for (int i = 0; i < 100; i++) begin
      if (miss_ready) begin
        e0 = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("accept_%0h", a), e0 >= 0, 1'b1);
    @(negedge clk);
    if (!hold) begin
      miss_valid  = 1'b0;
      miss_addr   = 32'hFFFF_FFFF;
      evict_dirty = 1'b1;
      evict_addr  = 32'hFFFF_FFFF;
      evict_data  = '1;
    end
  endtask

  task automatic wait_fills(input int n, input string tag);
    for (int i = 0; i < 200 && fill_addr_q.size() < n; i++) @(negedge clk);
    check(tag, fill_addr_q.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e0;
    int          e1;
    logic [31:0] exp_a [8];
    logic        exp_we[8];
    logic [31:0] exp_wd[4];

    reset       = 1'b1;
    miss_valid  = 1'b0;
    miss_addr   = '0;
    evict_dirty = 1'b0;
    evict_addr  = '0;
    evict_data  = '0;
    repeat (3) @(negedge clk);

    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_addr", fill_addr, 32'h0);
    check("rst_fill_data", fill_data, 128'h0);
    check("rst_crit_valid", crit_valid, 1'b0);
    check("rst_crit_data", crit_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Clean miss at 0x1234.
    clear_logs();
`ifdef CACHELINE_FILL_CWF_EN
    exp_a[0:3] = '{32'h1234, 32'h1238, 32'h123C, 32'h1230};
`else
    exp_a[0:3] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
`endif
    start_miss(32'h0000_1234, 1'b0, 32'hDEAD_0000, '1, 1'b0, e0);
    wait_fills(1, "clean_fill_count");
    check("clean_beat_count", beat_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < beat_addr_q.size(); i++) begin
      check($sformatf("clean_beat%0d_addr", i), beat_addr_q[i], exp_a[i]);
      check($sformatf("clean_beat%0d_we", i), beat_we_q[i], 1'b0);
    end
    if (fill_addr_q.size() > 0) begin
      check("clean_latency", fill_cyc_q[0] + 1 - e0, 5);
      check("clean_fill_addr", fill_addr_q[0], 32'h1230);
      check("clean_fill_data", fill_data_q[0], 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795);
    end
    check("fill_addr_hold", fill_addr, 32'h1230);

    // Dirty miss: victim {4,3,2,1} at 0x2000, then fetch of 0x3000.
    clear_logs();
    exp_a  = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h3000, 32'h3004, 32'h3008, 32'h300C};
    exp_we = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_wd = '{32'd1, 32'd2, 32'd3, 32'd4};
    start_miss(32'h0000_3000, 1'b1, 32'h0000_2000, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, e0);
    wait_fills(1, "dirty_fill_count");
    check("dirty_beat_count", beat_addr_q.size(), 8);
    for (int i = 0; i < 8 && i < beat_addr_q.size(); i++) begin
      check($sformatf("dirty_beat%0d_addr", i), beat_addr_q[i], exp_a[i]);
      check($sformatf("dirty_beat%0d_we", i), beat_we_q[i], exp_we[i]);
      if (i < 4) check($sformatf("dirty_beat%0d_wdata", i), beat_wdata_q[i], exp_wd[i]);
    end
    if (fill_addr_q.size() > 0) begin
      check("dirty_latency", fill_cyc_q[0] + 1 - e0, 9);
      check("dirty_fill_addr", fill_addr_q[0], 32'h3000);
      check("dirty_fill_data", fill_data_q[0], 128'hA5A595A9_A5A595AD_A5A595A1_A5A595A5);
    end

    // Three wait states on beat 2 of a clean miss at 0x4000.
    clear_logs();
    stall_addr = 32'h4008;
    stall_left = 3;
    stall_seen = 0;
    exp_a[0:3] = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
    start_miss(32'h0000_4000, 1'b0, 32'h0, '0, 1'b0, e0);
    wait_fills(1, "stall_fill_count");
    check("stall_cycles", stall_seen, 3);
    check("stall_beat_count", beat_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < beat_addr_q.size(); i++)
      check($sformatf("stall_beat%0d_addr", i), beat_addr_q[i], exp_a[i]);
    if (fill_addr_q.size() > 0) begin
      check("stall_latency", fill_cyc_q[0] + 1 - e0, 8);
      check("stall_fill_data", fill_data_q[0], 128'hA5A5E5A9_A5A5E5AD_A5A5E5A1_A5A5E5A5);
    end

    // Reset while fill beat 1 is stalled.
    clear_logs();
    stall_addr = 32'h5004;
    stall_left = 50;
    start_miss(32'h0000_5000, 1'b0, 32'h0, '0, 1'b0, e0);
    @(negedge clk);
`ifndef CACHELINE_FILL_CWF_EN
    check("abort_beat1_addr", bus.mem_addr, 32'h5004);
`endif
    check("abort_req_before", bus.mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_req", bus.mem_req, 1'b0);
    check("abort_miss_ready", miss_ready, 1'b1);
    check("abort_fill_valid", fill_valid, 1'b0);
    reset      = 1'b0;
    stall_left = 0;
    repeat (12) @(negedge clk);
    check("abort_no_fill", fill_addr_q.size(), 0);
    clear_logs();
    start_miss(32'h0000_1234, 1'b0, 32'h0, '0, 1'b0, e0);
    wait_fills(1, "post_abort_fill_count");
    check("post_abort_beat_count", beat_addr_q.size(), 4);
    if (fill_addr_q.size() > 0) begin
      check("post_abort_latency", fill_cyc_q[0] + 1 - e0, 5);
      check("post_abort_fill_addr", fill_addr_q[0], 32'h1230);
      check("post_abort_fill_data", fill_data_q[0], 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795);
    end

    // miss_valid held through a busy miss.
    clear_logs();
    start_miss(32'h0000_6000, 1'b0, 32'h0, '0, 1'b1, e0);
    start_miss(32'h0000_7000, 1'b0, 32'h0, '0, 1'b0, e1);
    check("b2b_spacing", e1 - e0, 6);
    wait_fills(2, "b2b_fill_count");
    repeat (20) @(negedge clk);
    check("b2b_one_fill_each", fill_addr_q.size(), 2);
    if (fill_addr_q.size() >= 2) begin
      check("b2b_fill0_addr", fill_addr_q[0], 32'h6000);
      check("b2b_fill1_addr", fill_addr_q[1], 32'h7000);
    end

`ifdef CACHELINE_FILL_CWF_EN
    // Critical word first from the last word of the line.
    clear_logs();
    exp_a[0:3] = '{32'h123C, 32'h1230, 32'h1234, 32'h1238};
    start_miss(32'h0000_123C, 1'b0, 32'h0, '0, 1'b0, e0);
    wait_fills(1, "cwf_fill_count");
    check("cwf_beat_count", beat_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < beat_addr_q.size(); i++)
      check($sformatf("cwf_beat%0d_addr", i), beat_addr_q[i], exp_a[i]);
    check("cwf_crit_count", crit_cyc_q.size(), 1);
    if (crit_cyc_q.size() > 0) begin
      check("cwf_crit_timing", crit_cyc_q[0] + 1 - e0, 2);
      check("cwf_crit_data", crit_data_q[0], 32'hA5A5_B799);
    end
    if (fill_addr_q.size() > 0) begin
      check("cwf_latency", fill_cyc_q[0] + 1 - e0, 5);
      check("cwf_fill_data", fill_data_q[0], 128'hA5A5B799_A5A5B79D_A5A5B791_A5A5B795);
    end
`else
    check("no_cwf_crit_pulses", crit_total, 0);
    check("no_cwf_crit_data", crit_data, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
